if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 redirect_i  input  1  branch/jump/trap redirect request from the EX stage or Hazard Unit.
REQ-005 redirect_pc_i  input  32  target PC, valid when redirect_i=1.
REQ-006 if_id_stall_i  input  1  IF/ID register holding; the presented instruction is not consumed.
REQ-007 imem_req_o  output  1  instruction memory request.
REQ-008 imem_addr_o  output  32  request address, word-aligned.
REQ-009 imem_gnt_i  input  1  request accepted this cycle.
REQ-010 imem_rvalid_i  input  1  read data valid, one cycle per granted request, in order.
REQ-011 imem_rdata_i  input  32  instruction word.
REQ-012 if_pc_o  output  32  PC of the presented instruction, to IF/ID if_pc_i.
REQ-013 if_instr_o  output  32  presented instruction, to IF/ID if_instr_i.
REQ-014 if_valid_o  output  1  if_instr_o holds a real fetched instruction.
REQ-015 if_misaligned_o  output  1  redirect target not word-aligned (see Configuration).

Function
REQ-016 The FSM SHALL have states REQ (request outstanding), RESP (granted, awaiting rvalid) and OUT (instruction presented).
REQ-017 In REQ: imem_req_o=1, imem_addr_o=pc; on gnt go to RESP; otherwise stay.
REQ-018 In RESP: imem_req_o=0; on rvalid with kill=0, capture rdata and pc into the output registers, set if_valid_o, set pc=pc+4 (mod 2^32) and go to OUT; on rvalid with kill=1, discard, clear kill and go to REQ.
REQ-019 In OUT: if if_id_stall_i=0, the instruction is consumed at that clock edge, if_valid_o clears and the state goes to REQ; if if_id_stall_i=1, all outputs hold.
REQ-020 When if_valid_o=0, if_instr_o SHALL be the NOP encoding 32'h0000_0013 and if_pc_o SHALL be 0.
REQ-021 redirect_i has highest priority: pc<=redirect_pc_i and if_valid_o<=0, regardless of if_id_stall_i.
REQ-022 Redirect in REQ without gnt SHALL withdraw the request; the next cycle requests redirect_pc_i.
REQ-023 Redirect in REQ with gnt, or in RESP without rvalid, SHALL go to RESP with kill=1.
REQ-024 Redirect in RESP with rvalid SHALL discard rdata and go to REQ.
REQ-025 Redirect in OUT SHALL go to REQ.
REQ-026 Minimum latency from redirect to if_valid_o=1 is 3 cycles with gnt and rvalid each arriving in the earliest cycle.
REQ-027 At most one memory request SHALL be outstanding.

Reset
REQ-028 While rst_n=0 at a clock edge: pc=RESET_PC, state=REQ, kill=0, if_valid_o=0, if_instr_o=NOP, if_pc_o=0, if_misaligned_o=0.
REQ-029 Reset mid-transaction SHALL drop any pending response; an rvalid arriving after reset release in state REQ SHALL be ignored.

Configuration
REQ-030 Macro IF_MISALIGN_CHECK_EN defined: a redirect with redirect_pc_i[1:0]!=0 SHALL not issue a fetch; it sets if_misaligned_o=1 (held until the next redirect or reset) and keeps the FSM in REQ with imem_req_o=0.
REQ-031 Macro IF_MISALIGN_CHECK_EN undefined: if_misaligned_o is tied 0 and redirect_pc_i[1:0] is forced to 2'b00.

Structure
REQ-032 NOP_INSTRUCTION SHALL come from the shared definitions file; the fetch FSM state enum and the PC increment constant (4) SHALL live in the shared core package.
REQ-033 The block has no sub-modules; the FSM, PC register and output register are in one module.

Verification
REQ-034 Reset release, RESET_PC=0x100, gnt and rvalid immediate, rdata=0x00500093 -> addr 0x100 in cycle 1; if_valid_o=1, if_pc_o=0x100, if_instr_o=0x00500093 in cycle 3; next request at 0x104.
REQ-035 OUT state with if_id_stall_i=1 for 4 cycles -> outputs stable and imem_req_o=0; on stall release the next request at pc+4 follows.
REQ-036 Redirect to 0x200 while in RESP, rvalid the next cycle with 0xDEADBEEF -> data discarded, if_valid_o stays 0, next request at 0x200.
REQ-037 Redirect to 0x300 in OUT while stalled -> if_valid_o=0 and if_instr_o=0x00000013 next cycle, request at 0x300.
REQ-038 With IF_MISALIGN_CHECK_EN, redirect to 0x302 -> if_misaligned_o=1 and no request; a later redirect to 0x400 clears it and fetches 0x400.
REQ-039 gnt withheld for 5 cycles -> imem_req_o and imem_addr_o stable; pc wraps 0xFFFFFFFC to 0x00000000.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, PC step and the NOP filler word.
package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_RESP = 2'd1,
        FS_OUT  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INC          = 32'd4;
    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Single-outstanding instruction fetch FSM with redirect/kill handling and IF/ID output register.
// Optional misaligned-target trap enabled by defining IF_MISALIGN_CHECK_EN.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_i,
    input  logic [31:0]            redirect_pc_i,
    input  logic                   if_id_stall_i,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            if_pc_o,
    output logic [31:0]            if_instr_o,
    output logic                   if_valid_o,
    output logic                   if_misaligned_o
);

    fetch_state_e state, state_d;
    logic [31:0]  pc, pc_d;
    logic         kill, kill_d;
    logic         out_valid, valid_d;
    logic [31:0]  out_instr, instr_d;
    logic [31:0]  out_pc, opc_d;
    logic         misaligned;
    logic         gnt_acc;
    logic [31:0]  redirect_tgt;

    // Low address bits never reach the PC; a misaligned target is flagged separately.
    assign redirect_tgt = {redirect_pc_i[31:2], redirect_pc_i[1:0] & 2'b00};

`ifdef IF_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n)          misaligned <= 1'b0;
        else if (redirect_i) misaligned <= |redirect_pc_i[1:0];
    end
`else
    assign misaligned = 1'b0;
`endif

    // A flagged target parks the FSM in REQ without asserting the request.
    assign imem.imem_req  = (state == FS_REQ) && !misaligned;
    assign imem.imem_addr = pc;
    assign gnt_acc        = imem.imem_req && imem.imem_gnt;

    always_comb begin
        state_d = state;
        pc_d    = pc;
        kill_d  = kill;
        valid_d = out_valid;
        instr_d = out_instr;
        opc_d   = out_pc;

        case (state)
            FS_REQ: begin
                if (gnt_acc) state_d = FS_RESP;
            end
            FS_RESP: begin
                if (imem.imem_rvalid) begin
                    if (kill) begin
                        kill_d  = 1'b0;
                        state_d = FS_REQ;
                    end else begin
                        valid_d = 1'b1;
                        instr_d = imem.imem_rdata;
                        opc_d   = pc;
                        pc_d    = pc + PC_INC;
                        state_d = FS_OUT;
                    end
                end
            end
            FS_OUT: begin
                if (!if_id_stall_i) begin
                    valid_d = 1'b0;
                    instr_d = NOP_INSTRUCTION;
                    opc_d   = '0;
                    state_d = FS_REQ;
                end
            end
            default: state_d = FS_REQ;
        endcase

        // Redirect overrides everything above, stall included.
        if (redirect_i) begin
            pc_d    = redirect_tgt;
            valid_d = 1'b0;
            instr_d = NOP_INSTRUCTION;
            opc_d   = '0;
            case (state)
                FS_REQ: begin
                    state_d = gnt_acc ? FS_RESP : FS_REQ;
                    kill_d  = gnt_acc;
                end
                FS_RESP: begin
                    state_d = imem.imem_rvalid ? FS_REQ : FS_RESP;
                    kill_d  = !imem.imem_rvalid;
                end
                default: begin
                    state_d = FS_REQ;
                    kill_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FS_REQ;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            out_valid <= 1'b0;
            out_instr <= NOP_INSTRUCTION;
            out_pc    <= '0;
        end else begin
            state     <= state_d;
            pc        <= pc_d;
            kill      <= kill_d;
            out_valid <= valid_d;
            out_instr <= instr_d;
            out_pc    <= opc_d;
        end
    end

    assign if_pc_o         = out_pc;
    assign if_instr_o      = out_instr;
    assign if_valid_o      = out_valid;
    assign if_misaligned_o = misaligned;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed-vector bench for if_fetch_unit; imem responses driven cycle by cycle from the bench.
module tb_if_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_id_stall_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_valid_o;
    logic        if_misaligned_o;

    int n_chk;
    int n_err;

    if_fetch_unit_if imem ();

    if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .if_id_stall_i   (if_id_stall_i),
        .imem            (imem.master),
        .if_pc_o         (if_pc_o),
        .if_instr_o      (if_instr_o),
        .if_valid_o      (if_valid_o),
        .if_misaligned_o (if_misaligned_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // Advance one edge; outputs are all registered, so sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
        chk({tag, ".valid"}, {31'b0, if_valid_o}, {31'b0, v});
        chk({tag, ".pc"},    if_pc_o, pc);
        chk({tag, ".instr"}, if_instr_o, ins);
    endtask

    task automatic chk_req(input string tag, input logic r, input logic [31:0] a);
        chk({tag, ".req"}, {31'b0, imem.imem_req}, {31'b0, r});
        if (r) chk({tag, ".addr"}, imem.imem_addr, a);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        if_id_stall_i = 1'b0;
        imem.imem_gnt = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata = '0;

        step();
        step();
        chk_out("rst", 1'b0, 32'h0, NOP);
        chk("rst.mis", {31'b0, if_misaligned_o}, 32'h0);
        chk_req("rst", 1'b1, 32'h100);

        // reset release, immediate gnt/rvalid
        rst_n = 1'b1;
        imem.imem_gnt = 1'b1;
        chk_req("c1", 1'b1, 32'h100);
        step();
        chk_req("c2", 1'b0, 32'h0);
        imem.imem_gnt = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata = 32'h0050_0093;
        step();
        imem.imem_rvalid = 1'b0;
        chk_out("c3", 1'b1, 32'h100, 32'h0050_0093);
        chk_req("c3", 1'b0, 32'h0);

        // hold in OUT for 4 stalled cycles
        if_id_stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("stall", 1'b1, 32'h100, 32'h0050_0093);
            chk_req("stall", 1'b0, 32'h0);
        end
        if_id_stall_i = 1'b0;
        step();
        chk_out("consume", 1'b0, 32'h0, NOP);
        chk_req("consume", 1'b1, 32'h104);

        // redirect while awaiting rvalid: response killed
        imem.imem_gnt = 1'b1;
        step();
        imem.imem_gnt = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h200;
        step();
        redirect_i = 1'b0;
        chk_req("kill.resp", 1'b0, 32'h0);
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata = 32'hDEAD_BEEF;
        step();
        imem.imem_rvalid = 1'b0;
        chk_out("kill.drop", 1'b0, 32'h0, NOP);
        chk_req("kill.drop", 1'b1, 32'h200);

        // fetch 0x200, then redirect to 0x300 in OUT while stalled
        imem.imem_gnt = 1'b1;
        step();
        imem.imem_gnt = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata = 32'h1234_5678;
        step();
        imem.imem_rvalid = 1'b0;
        chk_out("f200", 1'b1, 32'h200, 32'h1234_5678);
        if_id_stall_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h300;
        step();
        redirect_i = 1'b0;
        chk_out("rd.out", 1'b0, 32'h0, NOP);
        chk_req("rd.out", 1'b1, 32'h300);
        // earliest gnt/rvalid: valid in the third cycle after the redirect
        if_id_stall_i = 1'b0;
        imem.imem_gnt = 1'b1;
        step();
        imem.imem_gnt = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata = 32'hAAAA_0001;
        step();
        imem.imem_rvalid = 1'b0;
        chk_out("lat3", 1'b1, 32'h300, 32'hAAAA_0001);
        step();
        chk_req("next304", 1'b1, 32'h304);

        // redirect in REQ without gnt withdraws the request
        redirect_i = 1'b1;
        redirect_pc_i = 32'h500;
        step();
        redirect_i = 1'b0;
        chk_req("rd.req", 1'b1, 32'h500);

        // redirect in REQ with gnt: granted fetch becomes a kill
        imem.imem_gnt = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h600;
        step();
        redirect_i = 1'b0;
        imem.imem_gnt = 1'b0;
        chk_req("rd.gnt", 1'b0, 32'h0);
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata = 32'h1111_1111;
        step();
        imem.imem_rvalid = 1'b0;
        chk_out("rd.gnt", 1'b0, 32'h0, NOP);
        chk_req("rd.gnt.next", 1'b1, 32'h600);

        // redirect coinciding with rvalid discards the data
        imem.imem_gnt = 1'b1;
        step();
        imem.imem_gnt = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata = 32'h2222_2222;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h700;
        step();
        redirect_i = 1'b0;
        imem.imem_rvalid = 1'b0;
        chk_out("rd.rv", 1'b0, 32'h0, NOP);
        chk_req("rd.rv", 1'b1, 32'h700);

        // gnt withheld 5 cycles at the top of the address space, then wrap
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_req("nogrant", 1'b1, 32'hFFFF_FFFC);
            step();
        end
        imem.imem_gnt = 1'b1;
        step();
        imem.imem_gnt = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata = 32'h3333_3333;
        step();
        imem.imem_rvalid = 1'b0;
        chk_out("wrap", 1'b1, 32'hFFFF_FFFC, 32'h3333_3333);
        step();
        chk_req("wrap", 1'b1, 32'h0);

        // misaligned redirect target
        redirect_i = 1'b1;
        redirect_pc_i = 32'h302;
        step();
        redirect_i = 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
        chk("mis.set", {31'b0, if_misaligned_o}, 32'h1);
        chk_req("mis.set", 1'b0, 32'h0);
        imem.imem_gnt = 1'b1;
        step();
        imem.imem_gnt = 1'b0;
        chk("mis.hold", {31'b0, if_misaligned_o}, 32'h1);
        chk_req("mis.hold", 1'b0, 32'h0);
`else
        chk("mis.tied", {31'b0, if_misaligned_o}, 32'h0);
        chk_req("mis.align", 1'b1, 32'h300);
`endif
        redirect_i = 1'b1;
        redirect_pc_i = 32'h400;
        step();
        redirect_i = 1'b0;
        chk("mis.clr", {31'b0, if_misaligned_o}, 32'h0);
        chk_req("mis.clr", 1'b1, 32'h400);
        imem.imem_gnt = 1'b1;
        step();
        imem.imem_gnt = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata = 32'h4444_4444;
        step();
        imem.imem_rvalid = 1'b0;
        chk_out("f400", 1'b1, 32'h400, 32'h4444_4444);

        // reset mid-transaction; late rvalid in REQ is ignored
        if_id_stall_i = 1'b0;
        step();
        imem.imem_gnt = 1'b1;
        step();
        imem.imem_gnt = 1'b0;
        rst_n = 1'b0;
        step();
        chk_out("mrst", 1'b0, 32'h0, NOP);
        chk_req("mrst", 1'b1, 32'h100);
        rst_n = 1'b1;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata = 32'h5555_5555;
        step();
        imem.imem_rvalid = 1'b0;
        chk_out("mrst.late", 1'b0, 32'h0, NOP);
        chk_req("mrst.late", 1'b1, 32'h100);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
